// File: rtl/aes_pkg.sv
// AES helpers shared by the cipher cores: GF(2^8) arithmetic, S-boxes, key-schedule word ops, state transforms.
// Latency: none; every function here is pure combinational logic.
// Backpressure: none; there is no flow control at this level.
// The state is 128 bits, indexed [0:127]. Bit 0 is the MSB of byte 0.
// Bytes are column-major: byte 4*c+r is at row r, column c.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, EXPAND, ROUND, DONE} inv_fsm_e;

    function automatic logic [7:0] xtimes(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtimes(x);
        end
        return p;
    endfunction

    // a^254 = a^-1 in GF(2^8) (0 maps to 0). The loop accumulates a^2 * a^4 * ... * a^128.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-boxes are computed (inverse, then affine map) instead of looked up from a 256-entry table.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] i;
        i = gf_inv(b);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input int j);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 1; k < 16; k++) begin
            if (k < j) r = xtimes(r);
        end
        return r;
    endfunction

    function automatic logic [31:0] rotword(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Row r is rotated right by r columns.
    function automatic logic [0:127] inv_shiftrows(input logic [0:127] s);
        logic [0:127] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[32*c + 8*r +: 8] = s[32*((c - r + 4) % 4) + 8*r +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] inv_subbytes(input logic [0:127] s);
        logic [0:127] o;
        for (int b = 0; b < 16; b++) o[8*b +: 8] = inv_sbox(s[8*b +: 8]);
        return o;
    endfunction

    // The 0e/0b/0d/09 multiples are built from x2, x4 and x8 (repeated xtimes).
    function automatic logic [0:127] inv_mixcolumns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a [4];
        logic [7:0]   m9 [4];
        logic [7:0]   mb [4];
        logic [7:0]   md [4];
        logic [7:0]   me [4];
        logic [7:0]   x2, x4, x8;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = s[32*c + 8*r +: 8];
                x2    = xtimes(a[r]);
                x4    = xtimes(x2);
                x8    = xtimes(x4);
                m9[r] = x8 ^ a[r];
                mb[r] = x8 ^ x2 ^ a[r];
                md[r] = x8 ^ x4 ^ a[r];
                me[r] = x8 ^ x4 ^ x2;
            end
            o[32*c      +: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            o[32*c + 8  +: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            o[32*c + 16 +: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            o[32*c + 24 +: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return o;
    endfunction

    function automatic logic [0:127] addroundkey(input logic [0:127] s, input logic [0:127] k);
        return s ^ k;
    endfunction

endpackage

// File: rtl/aes_key_expand.sv
// AES key expansion for Nk = 4/6/8. It produces the full 4*Nr+4 word schedule.
// Latency: combinational, zero cycles.
// Backpressure: none; the output follows key continuously.
// Ports: key [0:32*Nk-1] cipher key (MSB-first); w [0:32*(4*Nr+4)-1] schedule, with word i at w[32*i +: 32].
module aes_key_expand #(
    parameter int  Nk  = 4,
    parameter int  Nr  = 10,
    localparam int Nkb = 32*Nk,
    localparam int NW  = 4*Nr + 4
) (
    input  logic [0:Nkb-1]   key,
    output logic [0:32*NW-1] w
);
    import aes_pkg::*;

    // Each word is a separate net, so no signal depends on itself through the chain.
    for (genvar i = 0; i < NW; i++) begin : g_w
        logic [31:0] word;
        if (i < Nk) begin : g_key
            assign word = key[32*i +: 32];
        end else if (i % Nk == 0) begin : g_rot
            assign word = g_w[i-Nk].word ^ subword(rotword(g_w[i-1].word)) ^ {rcon(i / Nk), 24'h000000};
        end else if (Nk > 6 && i % Nk == 4) begin : g_sub
            assign word = g_w[i-Nk].word ^ subword(g_w[i-1].word);
        end else begin : g_cpy
            assign word = g_w[i-Nk].word ^ g_w[i-1].word;
        end
        assign w[32*i +: 32] = word;
    end

endmodule

// File: rtl/inv_cipher.sv
// Iterative AES inverse cipher: one round per clock, one block in flight.
// Latency: out_valid rises Nr+1 edges after the accept edge; the minimum accept-to-accept period is Nr+3 cycles.
// Backpressure: DONE holds out/out_valid until out_ready; in_ready is high only in IDLE.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready with in [0:127] and key [0:32*Nk-1];
//        out_valid/out_ready with out [0:127].
module inv_cipher #(
    parameter int  Nk  = 4,
    parameter int  Nr  = 10,
    localparam int Nkb = 32*Nk
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [0:127]   in,
    input  logic [0:Nkb-1] key,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [0:127]   out
);
    import aes_pkg::*;

    localparam int NW = 4*Nr + 4;
    localparam int RW = $clog2(Nr + 1);

    inv_fsm_e         fsm_q, fsm_d;
    logic [0:127]     ct_q;
    logic [0:127]     state_q;
    logic [0:Nkb-1]   key_q;
    logic [0:32*NW-1] w_q;
    logic [0:32*NW-1] w_comb;
    logic [RW-1:0]    rnd_q;
    logic [0:127]     rk;
    logic [0:127]     sub_ark;
    logic [0:127]     round_out;

    aes_key_expand #(.Nk(Nk), .Nr(Nr)) u_key_expand (
        .key (key_q),
        .w   (w_comb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) fsm_q <= IDLE;
        else        fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d     = fsm_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) fsm_d = EXPAND;
            end
            EXPAND: fsm_d = ROUND;
            ROUND: begin
                if (rnd_q == '0) fsm_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Round keys are used last-to-first. Round 0 skips InvMixColumns.
    assign rk        = w_q[128*int'(rnd_q) +: 128];
    assign sub_ark   = addroundkey(inv_subbytes(inv_shiftrows(state_q)), rk);
    assign round_out = (rnd_q == '0) ? sub_ark : inv_mixcolumns(sub_ark);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ct_q    <= '0;
            key_q   <= '0;
            w_q     <= '0;
            state_q <= '0;
            rnd_q   <= '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        ct_q  <= in;
                        key_q <= key;
                    end
                end
                EXPAND: begin
                    // Round key Nr is taken from the combinational schedule, because w_q loads on this same edge.
                    w_q     <= w_comb;
                    state_q <= addroundkey(ct_q, w_comb[128*Nr +: 128]);
                    rnd_q   <= RW'(Nr - 1);
                end
                ROUND: begin
                    state_q <= round_out;
                    if (rnd_q != '0) rnd_q <= rnd_q - RW'(1);
                end
                default: ;
            endcase
        end
    end

    assign out = state_q;

endmodule

// File: tb/tb_inv_cipher.sv
// Directed bench for inv_cipher. It uses the FIPS-197 vectors for AES-128/192/256.
// It also covers backpressure, back-to-back accepts, reset mid-round and input isolation.
module tb_inv_cipher;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [0:127] in_bus;
    logic [0:255] key_bus;
    logic         out_ready;
    logic         iv [3];

    logic         ir4, ir6, ir8, ov4, ov6, ov8;
    logic [0:127] o4, o6, o8;
    logic         ir_a [3];
    logic         ov_a [3];
    logic [0:127] o_a  [3];

    assign ir_a[0] = ir4;
    assign ir_a[1] = ir6;
    assign ir_a[2] = ir8;
    assign ov_a[0] = ov4;
    assign ov_a[1] = ov6;
    assign ov_a[2] = ov8;
    assign o_a[0]  = o4;
    assign o_a[1]  = o6;
    assign o_a[2]  = o8;

    always #5 clk = ~clk;

    inv_cipher #(.Nk(4), .Nr(10)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir4), .in(in_bus),
        .key(key_bus[0:127]), .out_valid(ov4), .out_ready(out_ready), .out(o4)
    );
    inv_cipher #(.Nk(6), .Nr(12)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir6), .in(in_bus),
        .key(key_bus[0:191]), .out_valid(ov6), .out_ready(out_ready), .out(o6)
    );
    inv_cipher #(.Nk(8), .Nr(14)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir8), .in(in_bus),
        .key(key_bus), .out_valid(ov8), .out_ready(out_ready), .out(o8)
    );

    typedef struct {
        int           sel;
        logic [0:255] key;
        logic [0:127] ct;
        logic [0:127] pt;
        int           lat;
    } vec_t;

    vec_t vt [4];
    int   total = 0;
    int   bad   = 0;

    localparam logic [0:255] C1_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:255] B_KEY  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [0:127] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Entered and left at #1 after a posedge. Accepts one block, waits for the result,
    // checks the latency and the plaintext, then consumes the output.
    task automatic run_vec(input int sel, input logic [0:255] k, input logic [0:127] ct,
                           input logic [0:127] pt, input int lat, input string nm, input bit scramble);
        int n;
        bit got;
        key_bus = k;
        in_bus  = ct;
        iv[sel] = 1'b1;
        chk({nm, " ready before accept"}, 128'(ir_a[sel]), 128'd1);
        @(posedge clk); #1;
        iv[sel] = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            if (scramble) begin
                in_bus  = {$urandom(), $urandom(), $urandom(), $urandom()};
                key_bus = {$urandom(), $urandom(), $urandom(), $urandom(),
                           $urandom(), $urandom(), $urandom(), $urandom()};
            end
            @(posedge clk); #1;
            n++;
            if (ov_a[sel]) got = 1'b1;
        end
        chk({nm, " latency"}, 128'(n), 128'(lat));
        chk({nm, " plaintext"}, o_a[sel], pt);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, " idle in_ready"}, 128'(ir_a[sel]), 128'd1);
        chk({nm, " idle out_valid"}, 128'(ov_a[sel]), 128'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        int  vcnt;
        bit  got;

        vt[0] = '{0, B_KEY, B_CT, B_PT, 11};
        vt[1] = '{0, C1_KEY, C1_CT, PT_C, 11};
        vt[2] = '{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                  128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT_C, 13};
        vt[3] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  128'h8ea2b7ca516745bfeafc49904b496089, PT_C, 15};

        rst_n     = 1'b0;
        in_bus    = '0;
        key_bus   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) iv[i] = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready4", 128'(ir4), 128'd1);
        chk("reset in_ready6", 128'(ir6), 128'd1);
        chk("reset in_ready8", 128'(ir8), 128'd1);
        chk("reset out_valid4", 128'(ov4), 128'd0);
        chk("reset out4", o4, 128'd0);
        rst_n = 1'b1;

        // Known-answer vectors
        for (int i = 0; i < 4; i++) begin
            run_vec(vt[i].sel, vt[i].key, vt[i].ct, vt[i].pt, vt[i].lat, $sformatf("vec%0d", i), 1'b0);
        end

        // Backpressure: stall 20 cycles in DONE with in_valid pulses and junk on in/key
        key_bus = C1_KEY;
        in_bus  = C1_CT;
        iv[0]   = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ov4) got = 1'b1;
        end
        chk("stall reach done", 128'(got), 128'd1);
        for (int c = 0; c < 20; c++) begin
            iv[0]   = c[0];
            in_bus  = {$urandom(), $urandom(), $urandom(), $urandom()};
            key_bus = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk); #1;
            chk($sformatf("stall out c%0d", c), o4, PT_C);
            chk($sformatf("stall out_valid c%0d", c), 128'(ov4), 128'd1);
            chk($sformatf("stall in_ready c%0d", c), 128'(ir4), 128'd0);
        end

        // Release while in_valid is held: IDLE for one cycle, then back-to-back accepts
        iv[0]     = 1'b1;
        in_bus    = C1_CT;
        key_bus   = C1_KEY;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release in_ready", 128'(ir4), 128'd1);
        chk("release out_valid", 128'(ov4), 128'd0);
        n = 0;
        vcnt = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (ov4) begin
                vcnt++;
                chk("b2b plaintext", o4, PT_C);
            end
        end while (!ir4 && n < 40);
        iv[0]     = 1'b0;
        out_ready = 1'b0;
        chk("b2b accept period", 128'(n), 128'd13);
        chk("b2b valid cycles", 128'(vcnt), 128'd1);

        // Reset mid-ROUND: five edges after the accept edge rnd is 5
        key_bus = C1_KEY;
        in_bus  = C1_CT;
        iv[0]   = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst out_valid", 128'(ov4), 128'd0);
        chk("midrst out", o4, 128'd0);
        chk("midrst in_ready", 128'(ir4), 128'd1);
        rst_n = 1'b1;
        vcnt = 0;
        repeat (16) begin
            @(posedge clk); #1;
            if (ov4) vcnt++;
        end
        chk("midrst no spurious valid", 128'(vcnt), 128'd0);
        run_vec(0, C1_KEY, C1_CT, PT_C, 11, "post-reset C1", 1'b0);

        // Input isolation: in/key change every cycle after the accept
        run_vec(0, B_KEY, B_CT, B_PT, 11, "isolation B", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inv_cipher.md
# inv_cipher

Iterative AES inverse cipher (FIPS-197 InvCipher), one round per clock, with valid/ready handshakes on input and output. It is the decrypt counterpart to the team's pipelined encrypt core and consumes ciphertext blocks from the same 128-bit, MSB-first stream. It is parameterised for AES-128/192/256 with the same Nk/Nr convention. It trades throughput for area: one block is in flight at a time.

## Interface
- Nk, default 4: key length in 32-bit words (4, 6 or 8).
- Nr, default 10: number of rounds (10, 12 or 14); must match Nk.
- Nkb, localparam = 32*Nk: key width.
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  ciphertext/key valid.
- in_ready  output  1  block can accept a request.
- in  input  [0:127]  ciphertext; bit 0 is MSB of byte 0; column-major state.
- key  input  [0:Nkb-1]  cipher key, same ordering.
- out_valid  output  1  plaintext valid.
- out_ready  input  1  downstream accepts plaintext.
- out  output  [0:127]  plaintext.

## Operation
- FSM states: IDLE, EXPAND, ROUND, DONE.
- IDLE: in_ready=1. When in_valid=1, capture in→ct_q and key→key_q, then go to EXPAND.
- EXPAND: the combinational schedule of key_q (4*Nr+4 words) is registered into w.
  - Same cycle: state ← ct_q ^ w_comb[Nr] (round key Nr, taken from the combinational schedule).
  - rnd ← Nr-1; go to ROUND.
- ROUND, rnd ≥ 1: state ← InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ w[rnd]); rnd ← rnd-1.
- ROUND, rnd = 0: state ← InvSubBytes(InvShiftRows(state)) ^ w[0]; go to DONE.
- DONE: out_valid=1 and out=state, both held stable until out_ready=1. On out_ready=1, go to IDLE.
- in_ready is 0 in every state except IDLE. No request is accepted in the same cycle as the output handshake.
- in/key are sampled only on the accept edge. Changes at other times have no effect.
- Key expansion:
  - i%Nk==0: SubWord(RotWord) ^ Rcon(i/Nk).
  - Nk>6 and i%Nk==4: SubWord.
  - Otherwise: the previous word.
- rnd width: $clog2(Nr+1). It never underflows, because ROUND exits at 0.
- InvMixColumns coefficients {0e,0b,0d,09} are built from repeated xtimes.

## Timing
- Accept edge = edge at which IDLE sees in_valid=1 (call it edge 0).
- out_valid rises after edge Nr+1: 11 / 13 / 15 cycles for Nk = 4 / 6 / 8.
- Minimum period between accepts: Nr+3 cycles (output consumed immediately).
- out_ready=0 in DONE stalls indefinitely with out unchanged. out_ready outside DONE is ignored.
- Reset values: FSM=IDLE, in_ready=1 (from the first cycle after reset), out_valid=0, out=0, state=0, w=0, rnd=0.
- Reset asserted in any state, mid-operation included: the next edge returns to IDLE and the in-flight block is discarded. There is no spurious out_valid.
- in_valid held high across the DONE→IDLE transition: it is accepted on the first IDLE edge.

## Structure
- Package aes_pkg holds:
  - functions sbox, inv_sbox, rcon, xtimes, rotword, subword;
  - state-transform functions inv_shiftrows, inv_subbytes, inv_mixcolumns, addroundkey;
  - the FSM state enum typedef.
- The encrypt core migrates to aes_pkg later.
- One sub-module: aes_key_expand.
  - Combinational.
  - Parameters Nk, Nr; input key [0:Nkb-1]; output w [0:32*(4*Nr+4)-1].
  - Shared with the encrypt core.
- inv_cipher owns the FSM, handshakes, the registered schedule and the round datapath.

## Test plan
- AES-128 (FIPS-197 App. B): key 2b7e151628aed2a6abf7158809cf4f3c, in 3925841d02dc09fbdc118597196a0b32 → out 3243f6a8885a308d313198a2e0370734, out_valid exactly 11 cycles after accept.
- AES-128 (C.1): key 000102…0f, in 69c4e0d86a7b0430d8cdb78070b4c55a → out 00112233445566778899aabbccddeeff.
- Nk=6/Nr=12 (C.2): key 000102…17, in dda97ca4864cdfe06eaf70a0ec0d7191 → out 00112233…ff at 13 cycles. Nk=8/Nr=14 (C.3): key 00…1f, in 8ea2b7ca516745bfeafc49904b496089 → same plaintext at 15 cycles.
- Backpressure: hold out_ready=0 for 20 cycles in DONE → out and out_valid stable, in_ready=0 throughout, in_valid pulses ignored. Then out_ready=1 → IDLE next cycle. Back-to-back in_valid → next accept on that edge, period 13 cycles (Nk=4).
- Reset mid-ROUND (rnd=5): rst_n low one cycle → out_valid=0, out=0, in_ready=1. A fresh C.1 request then decrypts correctly.
- Input isolation: change in/key every cycle after accept → result still matches the captured vector.
